// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one fifo push port between N_REQ producers.
// Once granted, an owner keeps the port for up to MAX_BURST words.
module fifo_push_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]             gnt_o,
  output logic                         fifo_push_o,
  output logic [BIT_WIDTH-1:0]         fifo_push_data_o,
  input  logic                         fifo_full_i,
  output logic                         arb_busy_o,
  output logic [$clog2(N_REQ)-1:0]     cur_owner_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          st_q, st_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] bcnt_q, bcnt_d;

  logic            found;
  logic [IdxW-1:0] win_idx;
  logic [N_REQ-1:0] gnt;

  function automatic logic [IdxW-1:0] inc_mod(input logic [IdxW-1:0] v);
    if (v == IdxW'(N_REQ - 1)) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // First set request scanning from ptr upwards, wrapping modulo N_REQ.
  always_comb begin
    int unsigned c;
    found   = 1'b0;
    win_idx = '0;
    c       = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      c = 32'(ptr_q) + off;
      if (c >= N_REQ) begin
        c = c - N_REQ;
      end
      if (!found && req_i[c]) begin
        found   = 1'b1;
        win_idx = IdxW'(c);
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    gnt     = '0;
    unique case (st_q)
      StIdle: begin
        if (!rst_i && !fifo_full_i && found) begin
          gnt[win_idx] = 1'b1;
          if (MAX_BURST == 1) begin
            ptr_d = inc_mod(win_idx);
          end else begin
            st_d    = StOwn;
            owner_d = win_idx;
            bcnt_d  = CntW'(1);
          end
        end
      end
      StOwn: begin
        if (!req_i[owner_q]) begin
          // Owner withdrew: release with a one-cycle bubble.
          st_d  = StIdle;
          ptr_d = inc_mod(owner_q);
        end else if (!rst_i && !fifo_full_i) begin
          gnt[owner_q] = 1'b1;
          bcnt_d       = bcnt_q + 1'b1;
          if (bcnt_q + 1'b1 == CntW'(MAX_BURST)) begin
            st_d  = StIdle;
            ptr_d = inc_mod(owner_q);
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    fifo_push_data_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fifo_push_data_o = fifo_push_data_o | req_data_i[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  assign gnt_o       = gnt;
  assign fifo_push_o = |gnt;
  assign arb_busy_o  = (st_q == StOwn);
  assign cur_owner_o = (st_q == StOwn) ? owner_q : '0;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: a 2-producer burst arbiter and a 3-producer single-word arbiter,
// with a word scoreboard on the fifo push port.
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_REQ=2, MAX_BURST=4
  logic        rst_a, full_a, push_a, busy_a;
  logic [1:0]  req_a, gnt_a;
  logic [15:0] rdata_a;
  logic [7:0]  pdata_a;
  logic [0:0]  owner_a;

  // Instance B: N_REQ=3, MAX_BURST=1
  logic        rst_b, full_b, push_b, busy_b;
  logic [2:0]  req_b, gnt_b;
  logic [23:0] rdata_b;
  logic [7:0]  pdata_b;
  logic [1:0]  owner_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  int unsigned seq_a[2];
  int unsigned seq_b[3];

  fifo_push_arbiter #(.N_REQ(2), .BIT_WIDTH(8), .MAX_BURST(4)) u_dut_a (
    .clk_i            (clk),
    .rst_i            (rst_a),
    .req_i            (req_a),
    .req_data_i       (rdata_a),
    .gnt_o            (gnt_a),
    .fifo_push_o      (push_a),
    .fifo_push_data_o (pdata_a),
    .fifo_full_i      (full_a),
    .arb_busy_o       (busy_a),
    .cur_owner_o      (owner_a)
  );

  fifo_push_arbiter #(.N_REQ(3), .BIT_WIDTH(8), .MAX_BURST(1)) u_dut_b (
    .clk_i            (clk),
    .rst_i            (rst_b),
    .req_i            (req_b),
    .req_data_i       (rdata_b),
    .gnt_o            (gnt_b),
    .fifo_push_o      (push_b),
    .fifo_push_data_o (pdata_b),
    .fifo_full_i      (full_b),
    .arb_busy_o       (busy_b),
    .cur_owner_o      (owner_b)
  );

  function automatic logic [7:0] word(input int p, input int unsigned s);
    return 8'(p * 16 + 32'(s) + 1);
  endfunction

  // Each producer presents a fresh word after every grant it receives.
  always_comb begin
    rdata_a = {word(1, seq_a[1]), word(0, seq_a[0])};
    rdata_b = {word(2, seq_b[2]), word(1, seq_b[1]), word(0, seq_b[0])};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic push, input logic [7:0] data);
    if (push) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb observed=push expected=no_push", tag);
      end else begin
        chk({tag, "_data"}, 32'(data), 32'(sb_q.pop_front()));
      end
    end else begin
      chk({tag, "_zero"}, 32'(data), 32'd0);
    end
  endtask

  task automatic tick_a(input string tag, input logic [1:0] exp, input bit chk_st,
                        input logic exp_busy, input logic [0:0] exp_owner);
    #4;
    chk(tag, 32'(gnt_a), 32'(exp));
    chk({tag, "_push"}, 32'(push_a), 32'(|exp));
    if (chk_st) begin
      chk({tag, "_busy"}, 32'(busy_a), 32'(exp_busy));
      chk({tag, "_owner"}, 32'(owner_a), 32'(exp_owner));
    end
    for (int i = 0; i < 2; i++) if (exp[i]) sb_q.push_back(word(i, seq_a[i]));
    sb_check(tag, push_a, pdata_a);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (exp[i]) seq_a[i]++;
  endtask

  task automatic tick_b(input string tag, input logic [2:0] exp);
    #4;
    chk(tag, 32'(gnt_b), 32'(exp));
    chk({tag, "_push"}, 32'(push_b), 32'(|exp));
    chk({tag, "_busy"}, 32'(busy_b), 32'd0);
    chk({tag, "_owner"}, 32'(owner_b), 32'd0);
    for (int i = 0; i < 3; i++) if (exp[i]) sb_q.push_back(word(i, seq_b[i]));
    sb_check(tag, push_b, pdata_b);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (exp[i]) seq_b[i]++;
  endtask

  initial begin
    seq_a = '{0, 0};
    seq_b = '{0, 0, 0};
    rst_a = 1'b1; full_a = 1'b0; req_a = 2'b11;
    rst_b = 1'b1; full_b = 1'b0; req_b = 3'b111;

    // Reset with all requests high
    tick_a("rst0", 2'b00, 1'b0, 1'b0, 1'b0);
    tick_a("rst1", 2'b00, 1'b1, 1'b0, 1'b0);
    rst_a = 1'b0;

    // Two full bursts, then owner 0 again
    tick_a("b1", 2'b01, 1'b1, 1'b0, 1'b0);
    tick_a("b2", 2'b01, 1'b1, 1'b1, 1'b0);
    tick_a("b3", 2'b01, 1'b1, 1'b1, 1'b0);
    tick_a("b4", 2'b01, 1'b1, 1'b1, 1'b0);
    tick_a("b5", 2'b10, 1'b1, 1'b0, 1'b0);
    tick_a("b6", 2'b10, 1'b1, 1'b1, 1'b1);
    tick_a("b7", 2'b10, 1'b1, 1'b1, 1'b1);
    tick_a("b8", 2'b10, 1'b1, 1'b1, 1'b1);
    tick_a("b9", 2'b01, 1'b1, 1'b0, 1'b0);
    tick_a("b10", 2'b01, 1'b1, 1'b1, 1'b0);

    // fifo full mid-burst: burst is held, then completes before producer 1
    full_a = 1'b1;
    tick_a("f1", 2'b00, 1'b1, 1'b1, 1'b0);
    tick_a("f2", 2'b00, 1'b1, 1'b1, 1'b0);
    tick_a("f3", 2'b00, 1'b1, 1'b1, 1'b0);
    full_a = 1'b0;
    tick_a("c1", 2'b01, 1'b1, 1'b1, 1'b0);
    tick_a("c2", 2'b01, 1'b1, 1'b1, 1'b0);
    tick_a("c3", 2'b10, 1'b1, 1'b0, 1'b0);
    tick_a("c4", 2'b10, 1'b1, 1'b1, 1'b1);
    tick_a("c5", 2'b10, 1'b1, 1'b1, 1'b1);
    tick_a("c6", 2'b10, 1'b1, 1'b1, 1'b1);

    // Owner 0 withdraws after two words: one bubble, then producer 1
    tick_a("d1", 2'b01, 1'b1, 1'b0, 1'b0);
    tick_a("d2", 2'b01, 1'b1, 1'b1, 1'b0);
    req_a = 2'b10;
    tick_a("d3", 2'b00, 1'b1, 1'b1, 1'b0);
    tick_a("d4", 2'b10, 1'b1, 1'b0, 1'b0);
    tick_a("d5", 2'b10, 1'b1, 1'b1, 1'b1);

    // Reset during owner 1's burst
    req_a = 2'b11;
    rst_a = 1'b1;
    tick_a("e1", 2'b00, 1'b1, 1'b1, 1'b1);
    rst_a = 1'b0;
    tick_a("e2", 2'b01, 1'b1, 1'b0, 1'b0);
    tick_a("e3", 2'b01, 1'b1, 1'b1, 1'b0);
    rst_a = 1'b1;

    // Single-word bursts rotate through three producers
    tick_b("brst", 3'b000);
    rst_b = 1'b0;
    tick_b("r1", 3'b001);
    tick_b("r2", 3'b010);
    tick_b("r3", 3'b100);
    tick_b("r4", 3'b001);
    full_b = 1'b1;
    tick_b("r5", 3'b000);
    full_b = 1'b0;
    tick_b("r6", 3'b010);
    req_b = 3'b001;
    tick_b("r7", 3'b001);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
